// File: rtl/enc_snapshot_pkg.sv
// enc_snapshot_pkg: shared types, read-map addresses and status layout for the
// encoder snapshot readout controller.
package enc_snapshot_pkg;

  // Legacy-compatible state encodings, wrapped by the enum below.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_ABORT   = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    CAPTURE = ST_CAPTURE,
    HOLD    = ST_HOLD,
    ABORT   = ST_ABORT
  } state_t;

  localparam logic [7:0]  ADDR_CNT_BASE   = 8'h00;
  localparam logic [7:0]  ADDR_DELTA_BASE = 8'h10;
  localparam logic [7:0]  ADDR_STATUS     = 8'hF0;
  localparam logic [7:0]  ADDR_MAGIC      = 8'hFF;
  localparam logic [31:0] MAGIC           = 32'hE5C0_0001;

  localparam int unsigned STAT_VALID_BIT   = 0;
  localparam int unsigned STAT_BUSY_BIT    = 1;
  localparam int unsigned STAT_TIMEOUT_BIT = 2;
  localparam int unsigned STAT_SEQ_LSB     = 8;

  // Status word: {16'h0, seq, 5'h0, timeout, busy, valid}
  function automatic logic [31:0] pack_status(input logic [7:0] seq,
                                              input logic       to,
                                              input logic       bsy,
                                              input logic       vld);
    logic [31:0] w;
    w                        = '0;
    w[STAT_VALID_BIT]        = vld;
    w[STAT_BUSY_BIT]         = bsy;
    w[STAT_TIMEOUT_BIT]      = to;
    w[STAT_SEQ_LSB +: 8]     = seq;
    return w;
  endfunction

endpackage

// File: rtl/enc_snapshot_ctrl_if.sv
// enc_snapshot_ctrl_if: SPI-side bus between spi_slave and the snapshot
// controller (chip select, read address, read data).
interface enc_snapshot_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              spi_cs;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_out;

  modport master (output spi_cs, output data_addr, input  data_out);
  modport slave  (input  spi_cs, input  data_addr, output data_out);
endinterface

// File: rtl/enc_snapshot_ctrl_cs_sync_edge.sv
// cs_sync_edge: synchronises the raw, asynchronous SPI chip select and
// produces one-cycle rise/fall pulses. Flops clear to 0 so that a CS already
// low when reset is released does not look like a fresh falling edge.
module cs_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic cs_raw,
  output logic cs_rise,
  output logic cs_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   cs_q;

  // Synchroniser chain followed by a single edge-detect flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cs_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cs_raw};
      cs_q   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign cs_fall = cs_q & ~sync_q[SYNC_STAGES-1];
  assign cs_rise = ~cs_q & sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/enc_snapshot_ctrl.sv
// enc_snapshot_ctrl: captures all encoder counters into shadow registers on
// each SPI chip-select fall and serves them, optional deltas and a status
// word by read address, so a whole transaction sees one coherent snapshot.
// Optional feature macro: ENC_SNAP_DELTA_EN (prev regs + delta reads).
module enc_snapshot_ctrl
  import enc_snapshot_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  enc_snapshot_ctrl_if.slave      spi,
  input  logic [NUM_CH*CNT_W-1:0] cnt_in,
  output logic                    snap_valid,
  output logic [7:0]              snap_seq,
  output logic                    busy,
  output logic                    timeout
);

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic              cs_rise;
  logic              cs_fall;
  logic [CNT_W-1:0]  shadow [NUM_CH];
`ifdef ENC_SNAP_DELTA_EN
  logic [CNT_W-1:0]  prev   [NUM_CH];
`endif
  logic [ADDR_W-1:0] addr;
  logic [31:0]       addr_ext;
  logic [31:0]       rd_data;

  cs_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_cs_sync (
    .clk     (clk),
    .reset   (reset),
    .cs_raw  (spi.spi_cs),
    .cs_rise (cs_rise),
    .cs_fall (cs_fall)
  );

  // Transaction FSM with CS-low watchdog; a rise seen during CAPTURE still
  // lets the capture finish and returns straight to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= '0;
      snap_seq   <= '0;
      snap_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cs_fall) state <= CAPTURE;
        end
        CAPTURE: begin
          snap_seq   <= snap_seq + 8'd1;
          snap_valid <= 1'b1;
          timeout    <= 1'b0;
          timer      <= '0;
          state      <= cs_rise ? IDLE : HOLD;
        end
        HOLD: begin
          if (cs_rise) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == TMR_LAST) begin
            state   <= ABORT;
            timeout <= 1'b1;
            timer   <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ABORT: begin
          if (cs_rise) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == CAPTURE) || (state == HOLD);

  // Shadow (and previous-snapshot) registers load only in CAPTURE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow <= '{default: '0};
`ifdef ENC_SNAP_DELTA_EN
      prev   <= '{default: '0};
`endif
    end else if (state == CAPTURE) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
`ifdef ENC_SNAP_DELTA_EN
        prev[i]   <= shadow[i];
`endif
        shadow[i] <= cnt_in[i*CNT_W +: CNT_W];
      end
    end
  end

  assign addr     = spi.data_addr;
  assign addr_ext = 32'(addr);

  // Read-map decode; only snapshot registers are visible, never live counts.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (addr_ext == 32'(ADDR_CNT_BASE) + i) rd_data = 32'(shadow[i]);
`ifdef ENC_SNAP_DELTA_EN
      if (addr_ext == 32'(ADDR_DELTA_BASE) + i) rd_data = 32'(CNT_W'(shadow[i] - prev[i]));
`endif
    end
    if (addr_ext == 32'(ADDR_STATUS)) rd_data = pack_status(snap_seq, timeout, busy, snap_valid);
    if (addr_ext == 32'(ADDR_MAGIC))  rd_data = MAGIC;
  end

  // Registered read data towards spi_slave.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) spi.data_out <= '0;
    else        spi.data_out <= rd_data;
  end

endmodule
